// File: rtl/pong_vga_renderer_if.sv
// pong_vga_renderer_if: actor positions from the game controller to the renderer.
//   ballX_in      [7:0]  ball upper-left x, game cells
//   ballY_in      [6:0]  ball upper-left y, game cells
//   playerXPos_in [7:0]  player paddle upper-left x
//   playerYPos_in [6:0]  player paddle upper-left y
//   comXPos_in    [7:0]  com paddle upper-left x
//   comYPos_in    [6:0]  com paddle upper-left y
// Modports: master = game controller (drives), slave = renderer (samples).
interface pong_vga_renderer_if;
    logic [7:0] ballX_in;
    logic [6:0] ballY_in;
    logic [7:0] playerXPos_in;
    logic [6:0] playerYPos_in;
    logic [7:0] comXPos_in;
    logic [6:0] comYPos_in;

    modport master (
        output ballX_in, ballY_in, playerXPos_in, playerYPos_in, comXPos_in, comYPos_in
    );

    modport slave (
        input ballX_in, ballY_in, playerXPos_in, playerYPos_in, comXPos_in, comYPos_in
    );
endinterface

// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer: 640x480@60 Hz VGA timing plus Pong scene rendering on a 160x120 cell grid
// (4x4 screen pixels per cell), drawn from a once-per-frame snapshot of the actor positions.
// Ports:
//   PIXEL_CLK        in   25 MHz pixel clock
//   RESET            in   synchronous, active-high reset
//   pos_if           in   actor positions (slave modport)
//   HSYNC, VSYNC     out  active-low syncs, registered
//   RGB        [7:0] out  RGB332 pixel colour, registered (aligned with the syncs)
//   GAME_TICK        out  one-cycle pulse per frame, cycle after the position snapshot
//   frame_count_out  out  frames since reset, wrapping at 16 bits
module pong_vga_renderer #(
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned BLOCK    = 4,
    parameter int unsigned PADDLE_H = 32,
    parameter logic [7:0]  BALL_RGB = 8'hFC,
    parameter logic [7:0]  FG_RGB   = 8'hFF
) (
    input  logic                 PIXEL_CLK,
    input  logic                 RESET,
    pong_vga_renderer_if.slave   pos_if,
    output logic                 HSYNC,
    output logic                 VSYNC,
    output logic [7:0]           RGB,
    output logic                 GAME_TICK,
    output logic [15:0]          frame_count_out
);

    localparam logic [9:0] H_LAST      = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST      = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_W     = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W     = 10'(V_VIS);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [8:0] BLOCK_9     = 9'(BLOCK);
    localparam logic [8:0] PADDLE_H_9  = 9'(PADDLE_H);
    // Centre line occupies the two cell columns either side of the screen midpoint.
    localparam logic [7:0] CENTRE_L    = 8'(H_VIS / 8 - 1);
    localparam logic [7:0] CENTRE_R    = 8'(H_VIS / 8);

    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic [7:0]  r_sbx;
    logic [6:0]  r_sby;
    logic [7:0]  r_spx;
    logic [6:0]  r_spy;
    logic [7:0]  r_scx;
    logic [6:0]  r_scy;
    logic        r_hsync;
    logic        r_vsync;
    logic [7:0]  r_rgb;
    logic        r_tick;
    logic [15:0] r_frame_count;

    logic [7:0]  w_gx;
    logic [6:0]  w_gy;
    logic [8:0]  w_gx9;
    logic [8:0]  w_gy9;
    logic        w_visible;
    logic        w_ball;
    logic        w_player;
    logic        w_com;
    logic        w_centre;
    logic        w_latch;
    logic        w_hsync_next;
    logic        w_vsync_next;
    logic [7:0]  w_rgb_next;
    logic        w_h_wrap;
    logic        w_v_wrap;

    always_comb begin
        w_gx  = r_hcount[9:2];
        w_gy  = r_vcount[8:2];
        // 9-bit zero-extended compares so x+BLOCK / y+PADDLE_H never wrap round to 0.
        w_gx9 = {1'b0, w_gx};
        w_gy9 = {2'b00, w_gy};

        w_visible = (r_hcount < H_VIS_W) && (r_vcount < V_VIS_W);

        w_ball   = ({1'b0, r_sbx} <= w_gx9) && (w_gx9 < ({1'b0, r_sbx} + BLOCK_9)) &&
                   ({2'b00, r_sby} <= w_gy9) && (w_gy9 < ({2'b00, r_sby} + BLOCK_9));
        w_player = ({1'b0, r_spx} <= w_gx9) && (w_gx9 < ({1'b0, r_spx} + BLOCK_9)) &&
                   ({2'b00, r_spy} <= w_gy9) && (w_gy9 < ({2'b00, r_spy} + PADDLE_H_9));
        w_com    = ({1'b0, r_scx} <= w_gx9) && (w_gx9 < ({1'b0, r_scx} + BLOCK_9)) &&
                   ({2'b00, r_scy} <= w_gy9) && (w_gy9 < ({2'b00, r_scy} + PADDLE_H_9));
        // Dashes: 4 cells on, 4 cells off.
        w_centre = ((w_gx == CENTRE_L) || (w_gx == CENTRE_R)) && !w_gy[2];

        w_rgb_next = 8'h00;
        if (!w_visible) begin
            w_rgb_next = 8'h00;
        end else if (w_ball) begin
            w_rgb_next = BALL_RGB;
        end else if (w_player || w_com) begin
            w_rgb_next = FG_RGB;
        end else if (w_centre) begin
            w_rgb_next = FG_RGB;
        end

        w_hsync_next = !((r_hcount >= H_SYNC_FIRST) && (r_hcount <= H_SYNC_LAST));
        w_vsync_next = !((r_vcount >= V_SYNC_FIRST) && (r_vcount <= V_SYNC_LAST));

        // Snapshot point: first pixel of the first blanking line.
        w_latch  = (r_hcount == 10'd0) && (r_vcount == V_VIS_W);
        w_h_wrap = (r_hcount == H_LAST);
        w_v_wrap = (r_vcount == V_LAST);
    end

    always_ff @(posedge PIXEL_CLK) begin
        if (RESET) begin
            r_hcount      <= 10'd0;
            r_vcount      <= 10'd0;
            r_sbx         <= 8'd0;
            r_sby         <= 7'd0;
            r_spx         <= 8'd0;
            r_spy         <= 7'd0;
            r_scx         <= 8'd0;
            r_scy         <= 7'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb         <= 8'h00;
            r_tick        <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            if (w_h_wrap) begin
                r_hcount <= 10'd0;
                r_vcount <= w_v_wrap ? 10'd0 : r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end

            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
            r_rgb   <= w_rgb_next;
            r_tick  <= w_latch;

            if (w_latch) begin
                r_sbx         <= pos_if.ballX_in;
                r_sby         <= pos_if.ballY_in;
                r_spx         <= pos_if.playerXPos_in;
                r_spy         <= pos_if.playerYPos_in;
                r_scx         <= pos_if.comXPos_in;
                r_scy         <= pos_if.comYPos_in;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign HSYNC           = r_hsync;
    assign VSYNC           = r_vsync;
    assign RGB             = r_rgb;
    assign GAME_TICK       = r_tick;
    assign frame_count_out = r_frame_count;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Bench for pong_vga_renderer. Expected outputs are queued against the absolute clock count
// since reset release; a monitor pops each one on the falling edge of the cycle it is due.
module tb_pong_vga_renderer;

    localparam longint LINE  = 800;
    localparam longint FRAME = 420000;

    typedef struct packed {
        logic [63:0] cyc;
        logic [2:0]  kind;   // 0 rgb, 1 hsync, 2 vsync, 3 tick, 4 frame count
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync;
    logic        vsync;
    logic [7:0]  rgb;
    logic        tick;
    logic [15:0] fcnt;

    exp_t   sb[$];
    int     n_vec    = 0;
    int     n_err    = 0;
    longint cyc      = 0;
    int     tick_cnt = 0;

    pong_vga_renderer_if pos_if ();

    pong_vga_renderer dut (
        .PIXEL_CLK       (clk),
        .RESET           (rst),
        .pos_if          (pos_if),
        .HSYNC           (hsync),
        .VSYNC           (vsync),
        .RGB             (rgb),
        .GAME_TICK       (tick),
        .frame_count_out (fcnt)
    );

    always #20 clk = ~clk;

    // Edge k after release shows the counter state k-1.
    initial forever begin
        @(posedge clk);
        cyc = rst ? 0 : cyc + 1;
    end

    initial forever begin : monitor
        exp_t        e;
        logic [15:0] act;
        string       kn;
        longint      s;
        @(negedge clk);
        if (tick === 1'b1) tick_cnt++;
        while (sb.size() > 0 && longint'(sb[0].cyc) <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                3'd0:    begin act = {8'h00, rgb};    kn = "rgb";   end
                3'd1:    begin act = {15'h0, hsync};  kn = "hsync"; end
                3'd2:    begin act = {15'h0, vsync};  kn = "vsync"; end
                3'd3:    begin act = {15'h0, tick};   kn = "tick";  end
                default: begin act = fcnt;            kn = "fcount"; end
            endcase
            n_vec++;
            if (longint'(e.cyc) != cyc || act !== e.val) begin
                n_err++;
                s = longint'(e.cyc) - 1;
                $display("FAIL %s cyc=%0d f=%0d x=%0d y=%0d: got %h, want %h (seen at cyc %0d)",
                         kn, e.cyc, s / FRAME, s % LINE, (s % FRAME) / LINE, act, e.val, cyc);
            end
        end
    end

    function automatic longint at(int f, int y, int x);
        return longint'(f) * FRAME + longint'(y) * LINE + longint'(x) + 1;
    endfunction

    // Ordered insert keeps the queue sorted by due cycle.
    function automatic void push_exp(longint c, logic [2:0] k, logic [15:0] v);
        exp_t e;
        int   i;
        e.cyc  = 64'(c);
        e.kind = k;
        e.val  = v;
        i = sb.size();
        while (i > 0 && longint'(sb[i-1].cyc) > c) i--;
        sb.insert(i, e);
    endfunction

    function automatic void push_rgb(int f, int y, int x, logic [7:0] v);
        push_exp(at(f, y, x), 3'd0, {8'h00, v});
    endfunction

    task automatic set_pos(input logic [7:0] bx, input logic [6:0] by, input logic [7:0] px,
                           input logic [6:0] py, input logic [7:0] cx, input logic [6:0] cy);
        pos_if.ballX_in      = bx;
        pos_if.ballY_in      = by;
        pos_if.playerXPos_in = px;
        pos_if.playerYPos_in = py;
        pos_if.comXPos_in    = cx;
        pos_if.comYPos_in    = cy;
    endtask

    task automatic wait_cyc(input longint t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 3 * int'(FRAME);
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations still pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_pos(8'd100, 7'd50, 8'd3, 7'd0, 8'd156, 7'd0);
        repeat (3) @(negedge clk);
        n_vec += 5;
        if (hsync !== 1'b1) begin n_err++; $display("FAIL reset_hsync: got %b, want 1", hsync); end
        if (vsync !== 1'b1) begin n_err++; $display("FAIL reset_vsync: got %b, want 1", vsync); end
        if (rgb !== 8'h00) begin n_err++; $display("FAIL reset_rgb: got %h, want 00", rgb); end
        if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b, want 0", tick); end
        if (fcnt !== 16'd0) begin n_err++; $display("FAIL reset_fcount: got %0d, want 0", fcnt); end
    endtask

    task automatic test_sync();
        int lines[5] = '{0, 1, 479, 490, 524};
        for (int f = 0; f < 2; f++) begin
            foreach (lines[i]) begin
                push_exp(at(f, lines[i], 655), 3'd1, 16'd1);
                push_exp(at(f, lines[i], 656), 3'd1, 16'd0);
                push_exp(at(f, lines[i], 751), 3'd1, 16'd0);
                push_exp(at(f, lines[i], 752), 3'd1, 16'd1);
            end
            push_exp(at(f, 489, 799), 3'd2, 16'd1);
            push_exp(at(f, 490, 0),   3'd2, 16'd0);
            push_exp(at(f, 491, 799), 3'd2, 16'd0);
            push_exp(at(f, 492, 0),   3'd2, 16'd1);
            push_exp(at(f, 479, 799), 3'd3, 16'd0);
            push_exp(at(f, 479, 799), 3'd4, 16'(f));
            push_exp(at(f, 480, 0),   3'd3, 16'd1);
            push_exp(at(f, 480, 0),   3'd4, 16'(f + 1));
            push_exp(at(f, 480, 1),   3'd3, 16'd0);
        end
        // Frame 0 is drawn from the all-zero reset snapshot.
        push_rgb(0, 0, 0, 8'hFC);
        push_rgb(0, 0, 15, 8'hFC);
        push_rgb(0, 0, 16, 8'h00);
        push_rgb(0, 100, 8, 8'hFF);
        push_rgb(0, 100, 16, 8'h00);
        rst = 1'b0;
    endtask

    task automatic test_ball();
        for (int y = 200; y < 216; y++)
            for (int x = 400; x < 416; x++) push_rgb(1, y, x, 8'hFC);
        push_rgb(1, 200, 399, 8'h00);
        push_rgb(1, 200, 416, 8'h00);
        push_rgb(1, 200, 316, 8'hFF);
        push_rgb(1, 200, 323, 8'hFF);
        push_rgb(1, 200, 315, 8'h00);
        push_rgb(1, 200, 324, 8'h00);
        push_rgb(1, 216, 316, 8'h00);
        push_rgb(1, 0, 12, 8'hFF);
        push_rgb(1, 127, 27, 8'hFF);
        push_rgb(1, 0, 28, 8'h00);
        push_rgb(1, 128, 12, 8'h00);
        push_rgb(1, 0, 624, 8'hFF);
        push_rgb(1, 127, 639, 8'hFF);
        push_rgb(1, 10, 623, 8'h00);
        push_rgb(1, 520, 624, 8'h00);  // blanking line whose gy aliases onto the com paddle
        wait_cyc(at(0, 480, 0) + 2);
        set_pos(8'd3, 7'd20, 8'd3, 7'd10, 8'd156, 7'd0);
        drain();
    endtask

    task automatic test_paddle();
        for (int y = 40; y < 80; y++)
            for (int x = 12; x < 28; x++) push_rgb(2, y, x, 8'hFF);
        for (int y = 80; y < 96; y++)
            for (int x = 12; x < 28; x++) push_rgb(2, y, x, 8'hFC);
        for (int y = 96; y < 168; y += 7) begin
            push_rgb(2, y, 12, 8'hFF);
            push_rgb(2, y, 27, 8'hFF);
        end
        push_rgb(2, 167, 12, 8'hFF);
        push_rgb(2, 168, 12, 8'h00);
        push_rgb(2, 50, 11, 8'h00);
        push_rgb(2, 50, 28, 8'h00);
        push_rgb(2, 39, 12, 8'h00);
        // Next snapshot (end of frame 2) takes the shadow-test ball.
        set_pos(8'd20, 7'd80, 8'd3, 7'd10, 8'd156, 7'd0);
        drain();
    endtask

    task automatic test_shadow();
        int t0;
        int ys[3] = '{320, 327, 335};
        foreach (ys[i])
            for (int x = 80; x < 96; x++) push_rgb(3, ys[i], x, 8'hFC);
        push_rgb(3, 320, 79, 8'h00);
        push_rgb(3, 320, 96, 8'h00);
        push_rgb(3, 320, 240, 8'h00);
        push_rgb(3, 319, 80, 8'h00);
        push_rgb(3, 336, 80, 8'h00);
        for (int x = 240; x < 256; x++) begin
            push_rgb(4, 320, x, 8'hFC);
            push_rgb(4, 335, x, 8'hFC);
        end
        push_rgb(4, 320, 80, 8'h00);
        push_rgb(4, 320, 256, 8'h00);
        push_exp(at(3, 0, 0),   3'd4, 16'd3);
        push_exp(at(3, 480, 0), 3'd3, 16'd1);
        push_exp(at(3, 480, 0), 3'd4, 16'd4);
        push_exp(at(4, 0, 0),   3'd4, 16'd4);
        wait_cyc(at(3, 0, 0));
        t0 = tick_cnt;
        wait_cyc(at(3, 240, 0));
        pos_if.ballX_in = 8'd60;
        wait_cyc(at(4, 0, 0));
        n_vec++;
        if (tick_cnt - t0 != 1) begin
            n_err++;
            $display("FAIL ticks_per_frame: got %0d, want 1", tick_cnt - t0);
        end
        drain();
    endtask

    task automatic test_clip();
        set_pos(8'd158, 7'd118, 8'd3, 7'd10, 8'd156, 7'd0);
        for (int y = 472; y < 480; y++) begin
            for (int x = 0; x < 8; x++) push_rgb(5, y, x, 8'h00);
            for (int x = 632; x < 640; x++) push_rgb(5, y, x, 8'hFC);
        end
        push_rgb(5, 472, 640, 8'h00);
        push_rgb(5, 479, 647, 8'h00);
        push_rgb(5, 472, 631, 8'h00);
        push_rgb(5, 471, 632, 8'h00);
        drain();
    endtask

    task automatic test_mid_reset();
        int spurious;
        spurious = 0;
        // Reset lands where the next pixel would be the centre line (x=316, y=300).
        wait_cyc(at(6, 300, 316) - 1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec += 5;
            if (hsync !== 1'b1) begin n_err++; $display("FAIL mid_rst_hsync: got %b, want 1", hsync); end
            if (vsync !== 1'b1) begin n_err++; $display("FAIL mid_rst_vsync: got %b, want 1", vsync); end
            if (rgb !== 8'h00) begin n_err++; $display("FAIL mid_rst_rgb: got %h, want 00", rgb); end
            if (tick !== 1'b0) begin n_err++; $display("FAIL mid_rst_tick: got %b, want 0", tick); end
            if (fcnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_fcount: got %0d, want 0", fcnt); end
        end
        rst = 1'b0;
        for (int i = 1; i <= 760; i++) begin
            @(negedge clk);
            if (tick !== 1'b0) spurious++;
            if (i == 1) begin
                n_vec += 2;
                if (rgb !== 8'hFC) begin n_err++; $display("FAIL post_rst_rgb0: got %h, want fc", rgb); end
                if (hsync !== 1'b1) begin n_err++; $display("FAIL post_rst_hs1: got %b, want 1", hsync); end
            end
            if (i == 656 || i == 753) begin
                n_vec++;
                if (hsync !== 1'b1) begin n_err++; $display("FAIL post_rst_hs%0d: got %b, want 1", i, hsync); end
            end
            if (i == 657 || i == 752) begin
                n_vec++;
                if (hsync !== 1'b0) begin n_err++; $display("FAIL post_rst_hs%0d: got %b, want 0", i, hsync); end
            end
        end
        n_vec += 2;
        if (spurious != 0) begin n_err++; $display("FAIL post_rst_tick: got %0d pulses, want 0", spurious); end
        if (fcnt !== 16'd0) begin n_err++; $display("FAIL post_rst_fcount: got %0d, want 0", fcnt); end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_ball();
        test_paddle();
        test_shadow();
        test_clip();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pong_vga_renderer.md
Name: pong_vga_renderer

Overview:
- Downstream consumer of the game controller's actor positions.
- Generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock.
- Maps each pixel to the 160x120 game grid (4x4 screen pixels per game cell).
- Draws the ball, both paddles and a dashed centre line, using a frame-consistent shadow copy of the positions.
- Emits a once-per-frame tick that the team uses to advance the game state.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- BLOCK, 4, ball edge and paddle width in game cells
- PADDLE_H, 32, paddle height in game cells
- BALL_RGB, 8'hFC, ball colour (RGB332)
- FG_RGB, 8'hFF, paddle and centre-line colour

Ports:
- PIXEL_CLK  in  1  25 MHz pixel clock; only clock
- RESET  in  1  synchronous, active-high reset
- ballX_in  in  8  ball upper-left x, game cells
- ballY_in  in  7  ball upper-left y
- playerXPos_in  in  8  player paddle upper-left x
- playerYPos_in  in  7  player paddle upper-left y
- comXPos_in  in  8  com paddle upper-left x
- comYPos_in  in  7  com paddle upper-left y
- HSYNC  out  1  horizontal sync, active low
- VSYNC  out  1  vertical sync, active low
- RGB  out  8  pixel colour, RGB332
- GAME_TICK  out  1  one-cycle pulse per frame at start of vertical blank
- frame_count_out  out  16  frames since reset, wrapping

Behaviour:
- Clock and reset: one clock, PIXEL_CLK. RESET is synchronous and active-high.
- Reset values:
  - hcount=0, vcount=0
  - HSYNC=1, VSYNC=1, RGB=0, GAME_TICK=0
  - frame_count_out=0
  - all shadow registers 0
- hcount runs 0..799 and wraps to 0. When hcount wraps, vcount increments, running 0..524 and wrapping to 0.
- Sync windows: HSYNC is asserted (0) for hcount 656..751 inclusive. VSYNC is asserted (0) for vcount 490..491 inclusive.
- Visible region: hcount<640 and vcount<480.
- Game cell: gx = hcount[9:2] (0..159), gy = vcount[8:2] (0..119).
- Latency: HSYNC, VSYNC and RGB are registered. All three reflect counter state N at cycle N+1, so they stay mutually aligned.
- Shadow latch: at hcount==0 and vcount==480, all six position inputs are copied into shadow registers. Rendering uses only the shadows, so a whole visible frame is drawn from one snapshot.
- GAME_TICK: pulses high for exactly one cycle, in the cycle after the shadow latch. In that same cycle frame_count_out increments, wrapping from 65535 to 0.
- Hit tests:
  - All comparisons are done in 9 bits, zero-extended, so x+BLOCK and y+PADDLE_H cannot overflow.
  - ball: sbx <= gx < sbx+BLOCK and sby <= gy < sby+BLOCK.
  - paddle (each): spx <= gx < spx+BLOCK and spy <= gy < spy+PADDLE_H.
  - centre line: gx is 79 or 80, and gy[2]==0.
- Colour priority (highest first): outside visible region gives 0, then ball gives BALL_RGB, then paddle gives FG_RGB, then centre line gives FG_RGB, otherwise 0.
- Edge objects: objects partly off-grid, e.g. ball x=158, are clipped naturally. There is no wrap to x=0.
- RESET mid-frame: counters return to 0 on the next edge, and the first post-reset line starts a fresh frame. GAME_TICK is never emitted in the cycle after RESET.

Test Plan:
- Sync timing: release RESET and run 2 frames. Require:
  - line period 800 cycles, frame period 420000 cycles;
  - HSYNC low for 96 cycles starting 657 cycles after a line start (1-cycle latency);
  - VSYNC low for exactly 2 lines.
- Ball draw: ballX=100, ballY=50, paddles at x=3/156, y=0. Require:
  - RGB=8'hFC for screen x 400..415, y 200..215;
  - RGB=0 at x=399 and at x=416 on line 200.
- Paddle and priority: playerX=3, playerY=10, ball at (3,20). Require:
  - RGB=8'hFF at x 12..27, y 40..79, except the ball cells;
  - ball cells y 80..95, x 12..27 read 8'hFC (ball wins);
  - RGB=8'hFF at x=12, y=167 (paddle bottom at gy=41);
  - RGB=0 at x=12, y=168.
- Shadow consistency: change ballX from 20 to 60 at vcount=240. Require the whole current frame to draw the ball at gx 20..23, and the next frame at gx 60..63. GAME_TICK high exactly once per 420000 cycles; frame_count_out increments with it.
- Overflow/clipping: ballX=158, ballY=118. Require:
  - RGB=8'hFC at screen x 632..639, y 472..479;
  - no ball pixels at x 0..7.
- Mid-frame reset: assert RESET for 3 cycles at vcount=300. Require outputs at their reset values during reset, then HSYNC low at cycle 657 after release, no spurious GAME_TICK, and frame_count_out=0.
